// File: rtl/aes_pkg.sv
// Shared AES block geometry and the serializer state encoding.
package aes_pkg;

    localparam int AES_NBYTES     = 16;
    localparam int AES_BW         = 8;
    localparam int AES_BLOCK_BITS = AES_NBYTES * AES_BW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } ser_state_t;

endpackage : aes_pkg

// File: rtl/mod_reg16_serializer.sv
// Captures one AES state block and hands it to the downstream one-entry FIFO
// a byte at a time, most significant byte first, pulsing done_o at the end.
module mod_reg16_serializer
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_NBYTES,
    parameter int BW     = AES_BW
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load_i,
    input  logic [NBYTES*BW-1:0]   block_i,
    output logic                   load_ready_o,
    input  logic                   fifo_empty_i,
    input  logic                   abort_i,
    output logic [BW-1:0]          byte_o,
    output logic                   reg16_empty_o,
    output logic [3:0]             byte_idx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int         BLK_W    = NBYTES * BW;
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    ser_state_t         state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [3:0]         idx_q,   idx_d;
    logic               empty_q, empty_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               ready_q, ready_d;
    logic               xfer;

    // Same capture condition the FIFO evaluates, so both sides agree on every byte.
    assign xfer = (state_q == S_SEND) && fifo_empty_i && !empty_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        empty_d = empty_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;

        if (abort_i) begin
            state_d = S_IDLE;
            shreg_d = '0;
            idx_d   = '0;
            empty_d = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (load_i) begin
                        state_d = S_SEND;
                        shreg_d = block_i;
                        idx_d   = '0;
                        empty_d = 1'b0;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        shreg_d = shreg_q << BW;
                        // The final byte ends the block instead of wrapping the index.
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            empty_d = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    shreg_d = '0;
                    idx_d   = '0;
                    empty_d = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            empty_q <= empty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign byte_o        = shreg_q[BLK_W-1 -: BW];
    assign reg16_empty_o = empty_q;
    assign byte_idx_o    = idx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign load_ready_o  = ready_q;

endmodule : mod_reg16_serializer

// File: tb/tb_mod_reg16_serializer.sv
// Directed bench for mod_reg16_serializer; a bench-side one-entry FIFO model
// stands in for the downstream consumer in the throughput scenario.
module tb_mod_reg16_serializer;

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;

    logic         clk = 1'b0;
    logic         resetn;
    logic         load_i;
    logic [127:0] block_i;
    logic         load_ready_o;
    logic         fifo_empty_i;
    logic         abort_i;
    logic [7:0]   byte_o;
    logic         reg16_empty_o;
    logic [3:0]   byte_idx_o;
    logic         busy_o;
    logic         done_o;

    int errors = 0;
    int checks = 0;

    mod_reg16_serializer dut (
        .clk           (clk),
        .resetn        (resetn),
        .load_i        (load_i),
        .block_i       (block_i),
        .load_ready_o  (load_ready_o),
        .fifo_empty_i  (fifo_empty_i),
        .abort_i       (abort_i),
        .byte_o        (byte_o),
        .reg16_empty_o (reg16_empty_o),
        .byte_idx_o    (byte_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe whether the coming edge is a transfer, then advance one cycle.
    task automatic tick(output bit took, output logic [7:0] b);
        took = fifo_empty_i && !reg16_empty_o;
        b    = byte_o;
        step();
    endtask

    task automatic load(input logic [127:0] blk);
        block_i = blk;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
    endtask

    function automatic logic [7:0] byte_a(input int i);
        return 8'(i * 17);
    endfunction

    function automatic logic [7:0] byte_b(input int i);
        logic [127:0] t;
        t = BLK_B;
        return t[127 - 8*i -: 8];
    endfunction

    initial begin
        bit         took;
        logic [7:0] b;
        int         got;
        int         cyc;
        int         done_cyc;
        int         last_xfer;
        bit         done_seen;

        resetn       = 1'b1;
        load_i       = 1'b0;
        block_i      = '0;
        fifo_empty_i = 1'b1;
        abort_i      = 1'b0;
        repeat (2) step();
        resetn = 1'b0;
        step();

        // Reset values, and an empty serializer ignores an empty FIFO
        chk("rst_empty", 32'(reg16_empty_o), 32'd1);
        chk("rst_byte",  32'(byte_o),        32'h00);
        chk("rst_busy",  32'(busy_o),        32'd0);
        chk("rst_done",  32'(done_o),        32'd0);
        chk("rst_ready", 32'(load_ready_o),  32'd1);
        chk("rst_idx",   32'(byte_idx_o),    32'd0);
        repeat (2) step();
        chk("idle_idx",  32'(byte_idx_o),    32'd0);
        chk("idle_busy", 32'(busy_o),        32'd0);

        // Block A with the FIFO always ready: one byte per cycle, in order
        load(BLK_A);
        chk("t2_ready", 32'(load_ready_o), 32'd0);
        chk("t2_busy",  32'(busy_o),       32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_byte", 32'(byte_o),     32'(byte_a(i)));
            chk("t2_idx",  32'(byte_idx_o), 32'(i));
            tick(took, b);
        end
        chk("t2_done",  32'(done_o),        32'd1);
        chk("t2_empty", 32'(reg16_empty_o), 32'd1);
        chk("t2_busy0", 32'(busy_o),        32'd0);
        step();
        chk("t2_done0", 32'(done_o),        32'd0);
        chk("t2_rdy1",  32'(load_ready_o),  32'd1);

        // Block A through a one-entry FIFO model that drains the cycle after capture
        load(BLK_A);
        cyc = 0; got = 0; done_cyc = -1; last_xfer = -1;
        while (cyc < 60 && done_cyc < 0) begin
            tick(took, b);
            cyc++;
            if (took) begin
                chk("t3_byte", 32'(b), 32'(byte_a(got)));
                got++;
                last_xfer = cyc;
            end
            fifo_empty_i = !took;
            if (done_o) done_cyc = cyc;
        end
        chk("t3_count",     32'(got),       32'd16);
        chk("t3_last_xfer", 32'(last_xfer), 32'd31);
        chk("t3_done_cyc",  32'(done_cyc),  32'd31);
        step();
        chk("t3_done_1cyc", 32'(done_o),    32'd0);
        fifo_empty_i = 1'b1;

        // Stall at idx 5 for ten cycles, then release
        load(BLK_A);
        repeat (5) tick(took, b);
        chk("t4_idx", 32'(byte_idx_o), 32'd5);
        chk("t4_byte", 32'(byte_o),    32'h55);
        fifo_empty_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold_byte", 32'(byte_o),     32'h55);
            chk("t4_hold_idx",  32'(byte_idx_o), 32'd5);
        end
        fifo_empty_i = 1'b1;
        got = 0; done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            tick(took, b);
            if (took) begin
                chk("t4_byte_rest", 32'(b), 32'(byte_a(5 + got)));
                got++;
            end
            done_seen = done_o;
        end
        chk("t4_rest_count", 32'(got),       32'd11);
        chk("t4_done",       32'(done_seen), 32'd1);
        step();

        // Load of block B held during SEND and DONE is ignored
        load(BLK_A);
        block_i = BLK_B;
        load_i  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t5_byte",  32'(byte_o),       32'(byte_a(i)));
            chk("t5_ready", 32'(load_ready_o), 32'd0);
            tick(took, b);
        end
        chk("t5_done",       32'(done_o),       32'd1);
        chk("t5_ready_done", 32'(load_ready_o), 32'd0);
        step();
        load_i = 1'b0;
        chk("t5_no_capture", 32'(busy_o),        32'd0);
        chk("t5_empty",      32'(reg16_empty_o), 32'd1);
        chk("t5_ready_idle", 32'(load_ready_o),  32'd1);

        // Abort at idx 9 wins over a pending transfer
        load(BLK_A);
        repeat (9) tick(took, b);
        chk("t6_idx9",  32'(byte_idx_o), 32'd9);
        chk("t6_byte9", 32'(byte_o),     32'h99);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t6_empty", 32'(reg16_empty_o), 32'd1);
        chk("t6_busy",  32'(busy_o),        32'd0);
        chk("t6_idx0",  32'(byte_idx_o),    32'd0);
        chk("t6_ready", 32'(load_ready_o),  32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_done", 32'(done_o), 32'd0);
            step();
        end
        abort_i = 1'b1;
        block_i = BLK_B;
        load_i  = 1'b1;
        step();
        abort_i = 1'b0;
        load_i  = 1'b0;
        chk("t6_abort_wins", 32'(busy_o),        32'd0);
        chk("t6_abort_mt",   32'(reg16_empty_o), 32'd1);
        load(BLK_B);
        chk("t6_fresh_idx",   32'(byte_idx_o),    32'd0);
        chk("t6_fresh_byte",  32'(byte_o),        32'(byte_b(0)));
        chk("t6_fresh_empty", 32'(reg16_empty_o), 32'd0);
        tick(took, b);
        chk("t6_fresh_byte1", 32'(byte_o),        32'(byte_b(1)));

        // Asynchronous reset mid-block, observed before any clock edge
        tick(took, b);
        #1;
        resetn = 1'b1;
        #1;
        chk("t1_rst_empty", 32'(reg16_empty_o), 32'd1);
        chk("t1_rst_byte",  32'(byte_o),        32'h00);
        chk("t1_rst_busy",  32'(busy_o),        32'd0);
        chk("t1_rst_idx",   32'(byte_idx_o),    32'd0);
        chk("t1_rst_ready", 32'(load_ready_o),  32'd1);
        step();
        resetn = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mod_reg16_serializer
